// File: rtl/vme_reg_bank_pipe.sv
// VME-side control register bank: NREGS masked 32-bit registers with reset values, write
// strobes, unmapped-address errors and optional input/output pipeline stages.
module vme_reg_bank_pipe #(
  parameter int unsigned         NREGS    = 4,
  parameter int unsigned         ADDR_W   = 4,
  parameter logic [32*NREGS-1:0] RST_VAL  = {NREGS{32'h0}},
  parameter logic [32*NREGS-1:0] RW_MASK  = {NREGS{~32'h0}},
  parameter bit                  PIPE_IN  = 1'b1,
  parameter bit                  PIPE_OUT = 1'b1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [ADDR_W-1:0]    VMEAddr,
  input  logic [31:0]          VMEWrData,
  input  logic                 VMEWrMem,
  input  logic                 VMERdMem,
  output logic [31:0]          VMERdData,
  output logic                 VMERdDone,
  output logic                 VMEWrDone,
  output logic                 VMERdError,
  output logic                 VMEWrError,
  output logic [32*NREGS-1:0]  regs_o,
  output logic [NREGS-1:0]     wr_strobe_o
);

  localparam logic [ADDR_W:0] NRegsW = (ADDR_W+1)'(NREGS);

  function automatic logic mapped(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < NRegsW;
  endfunction

  logic              wr_v;
  logic [ADDR_W-1:0] wr_a;
  logic [31:0]       wr_dat;

  if (PIPE_IN) begin : g_pipe_in
    logic              wr_v_q;
    logic [ADDR_W-1:0] wr_a_q;
    logic [31:0]       wr_dat_q;

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        wr_v_q   <= 1'b0;
        wr_a_q   <= '0;
        wr_dat_q <= '0;
      end else begin
        wr_v_q   <= VMEWrMem;
        wr_a_q   <= VMEAddr;
        wr_dat_q <= VMEWrData;
      end
    end

    assign wr_v   = wr_v_q;
    assign wr_a   = wr_a_q;
    assign wr_dat = wr_dat_q;
  end else begin : g_no_pipe_in
    assign wr_v   = VMEWrMem;
    assign wr_a   = VMEAddr;
    assign wr_dat = VMEWrData;
  end

  logic [NREGS-1:0][31:0] regs_q, regs_d;
  logic [NREGS-1:0]       strobe_q, strobe_d;
  logic                   wr_done_q, wr_err_q;

  // Unmapped addresses match no k, so they leave the bank and strobes untouched.
  always_comb begin
    regs_d   = regs_q;
    strobe_d = '0;
    for (int unsigned k = 0; k < NREGS; k++) begin
      if (wr_v && (wr_a == ADDR_W'(k))) begin
        regs_d[k]   = (regs_q[k] & ~RW_MASK[32*k +: 32]) | (wr_dat & RW_MASK[32*k +: 32]);
        strobe_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      regs_q    <= RST_VAL & RW_MASK;
      strobe_q  <= '0;
      wr_done_q <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      strobe_q  <= strobe_d;
      wr_done_q <= wr_v;
      wr_err_q  <= wr_v & ~mapped(wr_a);
    end
  end

  logic [31:0] rd_data_c;
  logic        rd_err_c;

  always_comb begin
    rd_data_c = '0;
    for (int unsigned k = 0; k < NREGS; k++) begin
      if (VMERdMem && (VMEAddr == ADDR_W'(k))) begin
        rd_data_c = regs_q[k] & RW_MASK[32*k +: 32];
      end
    end
  end

  assign rd_err_c = VMERdMem & ~mapped(VMEAddr);

  if (PIPE_OUT) begin : g_pipe_out
    logic [31:0] rd_data_q;
    logic        rd_done_q, rd_err_q;

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        rd_data_q <= '0;
        rd_done_q <= 1'b0;
        rd_err_q  <= 1'b0;
      end else begin
        rd_data_q <= rd_data_c;
        rd_done_q <= VMERdMem;
        rd_err_q  <= rd_err_c;
      end
    end

    assign VMERdData  = rd_data_q;
    assign VMERdDone  = rd_done_q;
    assign VMERdError = rd_err_q;
  end else begin : g_no_pipe_out
    assign VMERdData  = rd_data_c;
    assign VMERdDone  = VMERdMem;
    assign VMERdError = rd_err_c;
  end

  assign regs_o      = regs_q;
  assign wr_strobe_o = strobe_q;
  assign VMEWrDone   = wr_done_q;
  assign VMEWrError  = wr_err_q;

endmodule

// File: tb/tb_vme_reg_bank_pipe.sv
// Bench for vme_reg_bank_pipe: a pipelined (PIPE_IN=PIPE_OUT=1) and an unpipelined instance
// share one stimulus stream; a cycle-scheduled reference model checks both every cycle.
module tb_vme_reg_bank_pipe;

  localparam logic [127:0] RstValP = {32'h0, 32'h0, 32'hA5A5_0003, 32'h0};
  localparam logic [127:0] MaskP   = {32'hFF00_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                      32'h0000_3FFF};
  localparam logic [31:0]  RSTV [4] = '{32'h0, 32'hA5A5_0003, 32'h0, 32'h0};
  localparam logic [31:0]  MASK [4] = '{32'h0000_3FFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                        32'hFF00_FFFF};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        wr_mem = 1'b0;
  logic        rd_mem = 1'b0;

  logic [1:0][31:0]  rd_data;
  logic [1:0]        rd_done, wr_done, rd_err, wr_err;
  logic [1:0][127:0] regs;
  logic [1:0][3:0]   strobe;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  vme_reg_bank_pipe #(
    .NREGS(4), .ADDR_W(4), .RST_VAL(RstValP), .RW_MASK(MaskP), .PIPE_IN(1'b1), .PIPE_OUT(1'b1)
  ) u_dut_pipe (
    .Clk(clk), .Rst(rst), .VMEAddr(addr), .VMEWrData(wdata), .VMEWrMem(wr_mem),
    .VMERdMem(rd_mem), .VMERdData(rd_data[0]), .VMERdDone(rd_done[0]),
    .VMEWrDone(wr_done[0]), .VMERdError(rd_err[0]), .VMEWrError(wr_err[0]),
    .regs_o(regs[0]), .wr_strobe_o(strobe[0])
  );

  vme_reg_bank_pipe #(
    .NREGS(4), .ADDR_W(4), .RST_VAL(RstValP), .RW_MASK(MaskP), .PIPE_IN(1'b0), .PIPE_OUT(1'b0)
  ) u_dut_comb (
    .Clk(clk), .Rst(rst), .VMEAddr(addr), .VMEWrData(wdata), .VMEWrMem(wr_mem),
    .VMERdMem(rd_mem), .VMERdData(rd_data[1]), .VMERdDone(rd_done[1]),
    .VMEWrDone(wr_done[1]), .VMERdError(rd_err[1]), .VMEWrError(wr_err[1]),
    .regs_o(regs[1]), .wr_strobe_o(strobe[1])
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: each access is turned into future events (commit, done pulses) placed
  // in an 8-slot calendar keyed by cycle number; latency depends on the instance.
  logic [31:0] mregs  [2][4];
  logic        er_done[2][8], er_err[2][8], ew_done[2][8], ew_err[2][8], pc_v[2][8];
  logic [31:0] er_data[2][8], pc_d[2][8];
  logic [3:0]  ew_strb[2][8], pc_a[2][8];
  int          cyc = 0;

  initial begin
    int s, lat, j;
    logic [31:0] m;
    forever begin
      @(negedge clk);
      s = cyc % 8;
      for (int d = 0; d < 2; d++) begin
        lat = (d == 0) ? 1 : 0;
        if (rst) begin
          for (int k = 0; k < 4; k++) mregs[d][k] = RSTV[k] & MASK[k];
          for (int i = 0; i < 8; i++) begin
            er_done[d][i] = 0; er_err[d][i] = 0; er_data[d][i] = '0;
            ew_done[d][i] = 0; ew_err[d][i] = 0; ew_strb[d][i] = '0; pc_v[d][i] = 0;
          end
        end else begin
          if (rd_mem) begin
            j = (cyc + lat) % 8;
            er_done[d][j] = 1'b1;
            er_err[d][j]  = (addr >= 4);
            er_data[d][j] = (addr < 4) ? (mregs[d][addr[1:0]] & MASK[addr[1:0]]) : 32'h0;
          end
          if (wr_mem) begin
            j = (cyc + lat) % 8;
            pc_v[d][j] = 1'b1; pc_a[d][j] = addr; pc_d[d][j] = wdata;
            j = (cyc + lat + 1) % 8;
            ew_done[d][j] = 1'b1;
            ew_err[d][j]  = (addr >= 4);
            ew_strb[d][j] = (addr < 4) ? (4'b0001 << addr[1:0]) : 4'b0000;
          end
        end
        chk($sformatf("model_dut%0d_cyc%0d", d, cyc),
            {rd_done[d], rd_err[d], rd_data[d], wr_done[d], wr_err[d], strobe[d], regs[d]},
            {er_done[d][s], er_err[d][s], er_data[d][s], ew_done[d][s], ew_err[d][s],
             ew_strb[d][s], mregs[d][3], mregs[d][2], mregs[d][1], mregs[d][0]});
        er_done[d][s] = 0; er_err[d][s] = 0; er_data[d][s] = '0;
        ew_done[d][s] = 0; ew_err[d][s] = 0; ew_strb[d][s] = '0;
        if (pc_v[d][s]) begin
          if (pc_a[d][s] < 4) begin
            m = MASK[pc_a[d][s][1:0]];
            mregs[d][pc_a[d][s][1:0]] = (mregs[d][pc_a[d][s][1:0]] & ~m) | (pc_d[d][s] & m);
          end
          pc_v[d][s] = 0;
        end
      end
      cyc++;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Write with explicit latency: comb instance acks 1 cycle later, pipelined one 2 cycles.
  task automatic wr_seq(input logic [3:0] a, input logic [31:0] dat, input logic err);
    addr = a; wdata = dat; wr_mem = 1'b1;
    @(negedge clk);
    chk("wr_lat_c0", {wr_done, wr_err}, 4'b0000);
    next_cycle();
    wr_mem = 1'b0;
    @(negedge clk);
    chk("wr_lat_c1", {wr_done[0], wr_done[1], wr_err[0], wr_err[1]}, {1'b0, 1'b1, 1'b0, err});
    next_cycle();
    @(negedge clk);
    chk("wr_lat_c2", {wr_done[0], wr_done[1], wr_err[0], wr_err[1]}, {1'b1, 1'b0, err, 1'b0});
    next_cycle();
  endtask

  task automatic rd_seq(input logic [3:0] a, input logic [31:0] exp, input logic err);
    addr = a; rd_mem = 1'b1;
    @(negedge clk);
    chk("rd_c0", {rd_done[0], rd_done[1], rd_err[1], rd_data[1]}, {1'b0, 1'b1, err, exp});
    next_cycle();
    rd_mem = 1'b0;
    @(negedge clk);
    chk("rd_c1", {rd_done[0], rd_err[0], rd_data[0], rd_done[1]}, {1'b1, err, exp, 1'b0});
    next_cycle();
  endtask

  typedef struct packed {
    logic        wr;
    logic [3:0]  a;
    logic [31:0] wdat;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t vt [7];

  initial begin
    logic [6:0]  hist;
    logic [31:0] b2b [4];

    vt[0] = '{wr: 1'b0, a: 4'd1,  wdat: 32'h0,         exp: 32'hA5A5_0003, err: 1'b0};
    vt[1] = '{wr: 1'b1, a: 4'd0,  wdat: 32'hFFFF_FFFF, exp: 32'h0000_3FFF, err: 1'b0};
    vt[2] = '{wr: 1'b1, a: 4'd5,  wdat: 32'h1234_5678, exp: 32'h0,         err: 1'b1};
    vt[3] = '{wr: 1'b1, a: 4'd3,  wdat: 32'hFFFF_FFFF, exp: 32'hFF00_FFFF, err: 1'b0};
    vt[4] = '{wr: 1'b1, a: 4'd1,  wdat: 32'h0,         exp: 32'h0,         err: 1'b0};
    vt[5] = '{wr: 1'b1, a: 4'd2,  wdat: 32'h0000_0001, exp: 32'h0000_0001, err: 1'b0};
    vt[6] = '{wr: 1'b0, a: 4'd15, wdat: 32'h0,         exp: 32'h0,         err: 1'b1};
    b2b = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {regs[0], regs[1], rd_done, wr_done, rd_err, wr_err, strobe},
        {RstValP & MaskP, RstValP & MaskP, 16'h0});
    next_cycle();

    for (int i = 0; i < 7; i++) begin
      if (vt[i].wr) wr_seq(vt[i].a, vt[i].wdat, vt[i].err);
      rd_seq(vt[i].a, vt[i].exp, vt[i].err);
    end

    // Same-cycle read and write of reg2 (currently 1) must return the old value.
    addr = 4'd2; wdata = 32'h2; wr_mem = 1'b1; rd_mem = 1'b1;
    @(negedge clk);
    chk("collide_comb", {rd_done[1], rd_data[1]}, {1'b1, 32'h1});
    next_cycle();
    wr_mem = 1'b0; rd_mem = 1'b0;
    @(negedge clk);
    chk("collide_pipe", {rd_done[0], rd_data[0]}, {1'b1, 32'h1});
    next_cycle();
    next_cycle();
    rd_seq(4'd2, 32'h2, 1'b0);

    for (int i = 0; i < 7; i++) begin
      wr_mem = (i < 4);
      addr   = 4'(i % 4);
      wdata  = b2b[i % 4];
      @(negedge clk);
      hist[i] = wr_done[0];
      next_cycle();
    end
    chk("b2b_done", {25'h0, hist}, {25'h0, 7'b0111100});
    rd_seq(4'd0, 32'h0000_1111, 1'b0);
    rd_seq(4'd1, 32'h2222_2222, 1'b0);
    rd_seq(4'd2, 32'h3333_3333, 1'b0);
    rd_seq(4'd3, 32'h4400_4444, 1'b0);

    // Reset lands while the pipelined write is still in flight.
    addr = 4'd1; wdata = 32'hCAFE_F00D; wr_mem = 1'b1;
    next_cycle();
    wr_mem = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_wr", {wr_done, regs[0], regs[1]}, {2'b00, RstValP & MaskP, RstValP & MaskP});
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_wr_after", {wr_done, strobe, regs[0][63:32]}, {2'b00, 8'h00, 32'hA5A5_0003});
    next_cycle();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b1; rd_mem = 1'b0; wr_mem = 1'b0;
      end else begin
        rst    = 1'b0;
        rd_mem = 1'($urandom_range(0, 1));
        wr_mem = 1'($urandom_range(0, 1));
        addr   = 4'($urandom_range(0, 7));
        wdata  = $urandom;
      end
      next_cycle();
    end
    rst = 1'b0; rd_mem = 1'b0; wr_mem = 1'b0;
    repeat (4) next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
